// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the uart_tx round-robin arbiter.
// Also provides the index-width helper used by rr_pick.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  localparam int GAP_DEF     = 16;
  localparam int TIMEOUT_DEF = 64;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// master is the arbiter side, slave is the producers plus uart_tx.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         uart_data;
  logic               uart_send;
  logic               uart_ready;

  modport master (
    input  req_valid,
    input  req_data,
    input  uart_ready,
    output req_ready,
    output uart_data,
    output uart_send
  );

  modport slave (
    output req_valid,
    output req_data,
    output uart_ready,
    input  req_ready,
    input  uart_data,
    input  uart_send
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req bit at or after ptr,
// wrapping modulo N_REQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W:0] pos;

  // Walk priority from lowest to highest so the nearest one wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    pos     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N_REQ)) begin
        pos = pos - (IDX_W + 1)'(N_REQ);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && pos == (IDX_W + 1)'(i)) begin
          gnt_idx = IDX_W'(i);
          any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between N_REQ byte producers,
// one byte per frame, with an idle gap and a busy-handshake timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int GAP_CYCLES   = GAP_DEF,
  parameter  int BUSY_TIMEOUT = TIMEOUT_DEF,
  localparam int IDX_W        = idx_w(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus,
  output logic              busy,
  output logic [IDX_W-1:0]  grant_id,
  output logic              timeout_err
);

  localparam int CMAX  = (GAP_CYCLES > BUSY_TIMEOUT) ?
                         GAP_CYCLES : BUSY_TIMEOUT;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(BUSY_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES > 1) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_e state_q, state_d;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       uart_data_q, uart_data_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             uart_send_q, uart_send_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [7:0]       sel_byte;
  logic             go;
  logic             tmo_hit;
  logic             gap_end;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_byte = bus.req_data[8*i +: 8];
      end
    end
  end

  assign go = (state_q == S_IDLE) &&
              bus.uart_ready && pick_any;

  // Decided one cycle early so the registered pulse lines up
  // with the counter reaching BUSY_TIMEOUT-1.
  assign tmo_hit = (state_q == S_WAIT_BUSY) &&
                   bus.uart_ready && (cnt_q == TMO_LAST);

  assign gap_end = (cnt_q == GAP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!bus.uart_ready) state_d = S_WAIT_DONE;
        else if (tmo_hit)    state_d = S_GAP;
      end
      S_WAIT_DONE: begin
        if (bus.uart_ready) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    uart_send_d   = go;
    req_ready_d   = '0;
    uart_data_d   = uart_data_q;
    grant_id_d    = grant_id_q;
    ptr_d         = ptr_q;
    busy_d        = (state_d != S_IDLE);
    timeout_err_d = tmo_hit;
    cnt_d         = '0;
    if (go) begin
      req_ready_d = N_REQ'(1) << pick_idx;
      uart_data_d = sel_byte;
      grant_id_d  = pick_idx;
      ptr_d       = (pick_idx == IDX_W'(N_REQ - 1)) ?
                    '0 : pick_idx + 1'b1;
    end
    if (state_d == state_q &&
        (state_q == S_WAIT_BUSY || state_q == S_GAP)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      grant_id_q    <= '0;
      cnt_q         <= '0;
      uart_data_q   <= 8'h00;
      req_ready_q   <= '0;
      uart_send_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      cnt_q         <= cnt_d;
      uart_data_q   <= uart_data_d;
      req_ready_q   <= req_ready_d;
      uart_send_q   <= uart_send_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.uart_data = uart_data_q;
  assign bus.uart_send = uart_send_q;
  assign bus.req_ready = req_ready_q;
  assign busy          = busy_q;
  assign grant_id      = grant_id_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter with
// behavioural requester, uart_tx and round-robin models.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N   = 4;
  localparam int GAP = 4;
  localparam int BT  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic       timeout_err;
  logic [1:0] grant_id;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ        (N),
    .GAP_CYCLES   (GAP),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int         vec, errs, cyc;
  logic [3:0] vld, pv;
  logic [7:0] bytes [N];
  bit         refill [N];
  int         wt [N];
  int         maxw;
  int         ref_ptr;
  bit         ignore, rnd_raise;
  int         tx_len, busy_left, w_cyc;
  logic       prev_send;
  int         n, cnt;
  int         ord [3];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Round robin by definition: nearest valid index from ptr.
  function automatic int rr_ref(logic [3:0] v, int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic push();
    bus.req_valid = vld;
    bus.req_data  = {bytes[3], bytes[2], bytes[1], bytes[0]};
  endtask

  task automatic check_out();
    int e;
    if (bus.uart_send) begin
      e = rr_ref(pv, ref_ptr);
      chk("send_width", 32'(prev_send), 0);
      if (e < 0) begin
        chk("spurious_send", 1, 0);
      end else begin
        chk("grant_id", 32'(grant_id), 32'(e));
        chk("req_ready", 32'(bus.req_ready), 32'(1) << e);
        chk("uart_data", 32'(bus.uart_data), 32'(bytes[e]));
        if (w_cyc >= 0)
          chk("gap_min", 32'(cyc - w_cyc >= GAP + 2), 1);
        ref_ptr = (e + 1) % N;
      end
      w_cyc = -1;
    end else if (bus.req_ready != 0) begin
      chk("ready_no_send", 32'(bus.req_ready), 0);
    end
  endtask

  task automatic tick();
    pv = vld;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) check_out();
    prev_send = bus.uart_send;
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i]) begin
        wt[i] = 0;
        if (refill[i] || (rnd_raise && $urandom_range(0, 1) == 1))
          bytes[i] = 8'($urandom);
        else
          vld[i] = 1'b0;
      end else if (vld[i]) begin
        wt[i]++;
        if (wt[i] > maxw) maxw = wt[i];
      end else if (rnd_raise && $urandom_range(0, 7) == 0) begin
        vld[i]   = 1'b1;
        bytes[i] = 8'($urandom);
      end
    end
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        bus.uart_ready = 1'b1;
        w_cyc = cyc;
      end
    end else if (bus.uart_send && !ignore) begin
      if (rnd_raise) tx_len = $urandom_range(2, 8);
      bus.uart_ready = 1'b0;
      busy_left = tx_len;
    end
    push();
  endtask

  task automatic wait_send(int budget, string tag, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.uart_send && k < budget);
    chk(tag, 32'(bus.uart_send), 1);
  endtask

  task automatic wait_idle(int budget, string tag);
    int k;
    k = 0;
    while ((busy || vld != 0) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic check_reset(string t);
    chk({t, "_data"}, 32'(bus.uart_data), 0);
    chk({t, "_send"}, 32'(bus.uart_send), 0);
    chk({t, "_rdy"}, 32'(bus.req_ready), 0);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_gid"}, 32'(grant_id), 0);
    chk({t, "_tmo"}, 32'(timeout_err), 0);
  endtask

  initial begin
    vec = 0; errs = 0; cyc = 0; maxw = 0;
    vld = '0; pv = '0; ref_ptr = 0;
    ignore = 0; rnd_raise = 0;
    tx_len = 6; busy_left = 0; w_cyc = -1;
    prev_send = 1'b0;
    ord = '{3, 0, 1};
    for (int i = 0; i < N; i++) begin
      bytes[i] = 8'h00; refill[i] = 0; wt[i] = 0;
    end
    bus.uart_ready = 1'b1;
    push();

    rst_n = 1'b0;
    repeat (3) tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single byte from requester 2
    bytes[2] = 8'h41; vld = 4'b0100; push();
    tick();
    chk("t1_send", 32'(bus.uart_send), 1);
    chk("t1_data", 32'(bus.uart_data), 32'h41);
    chk("t1_rdy", 32'(bus.req_ready), 32'b0100);
    chk("t1_gid", 32'(grant_id), 2);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_send_fall", 32'(bus.uart_send), 0);
    chk("t1_rdy_fall", 32'(bus.req_ready), 0);
    n = 0;
    while (!bus.uart_ready && n < 50) begin tick(); n++; end
    chk("t1_ready_back", 32'(bus.uart_ready), 1);
    repeat (GAP) tick();
    chk("t1_busy_gap", 32'(busy), 1);
    tick();
    chk("t1_busy_fall", 32'(busy), 0);

    // Round robin over 0,1,3 with ptr starting at 3
    vld = 4'b1011;
    bytes[0] = 8'h10; bytes[1] = 8'h21; bytes[3] = 8'h33;
    refill[0] = 1; refill[1] = 1; refill[3] = 1;
    push();
    for (int k = 0; k < 7; k++) begin
      wait_send(100, "rr_to", n);
      chk("rr_order", 32'(grant_id), 32'(ord[k % 3]));
    end
    // Last grant went to 3: only 0 and 3 remain
    vld[1] = 1'b0;
    for (int i = 0; i < N; i++) refill[i] = 0;
    push();
    wait_send(100, "wrap_to", n);
    chk("wrap_gid", 32'(grant_id), 0);
    wait_idle(200, "wrap_idle");

    // Transmitter ignores send
    ignore = 1;
    bytes[2] = 8'hA2; bytes[3] = 8'hB3; vld = 4'b1100; push();
    wait_send(20, "to_send", n);
    chk("to_gid", 32'(grant_id), 2);
    for (int k = 1; k <= BT; k++) begin
      tick();
      chk("to_err", 32'(timeout_err), 32'(k == BT));
    end
    chk("to_busy", 32'(busy), 1);
    tick();
    chk("to_pulse", 32'(timeout_err), 0);
    wait_send(20, "to_next", n);
    chk("to_next_lat", 32'(n), GAP);
    chk("to_next_gid", 32'(grant_id), 3);
    wait_idle(100, "to_idle");
    ignore = 0;

    // Valid while uart_ready is low
    bus.uart_ready = 1'b0;
    bytes[0] = 8'h5A; vld[0] = 1'b1; push();
    cnt = 0;
    repeat (6) begin tick(); if (bus.uart_send) cnt++; end
    chk("rl_nosend", 32'(cnt), 0);
    bus.uart_ready = 1'b1; push();
    tick();
    chk("rl_send", 32'(bus.uart_send), 1);
    chk("rl_gid", 32'(grant_id), 0);
    wait_idle(100, "rl_idle");

    // Async reset while waiting for the frame to finish
    bytes[2] = 8'h77; vld = 4'b0100; push();
    wait_send(20, "ar_send", n);
    tick(); tick();
    chk("ar_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    ref_ptr = 0; busy_left = 0; w_cyc = -1;
    bus.uart_ready = 1'b1;
    bytes[1] = 8'h31; bytes[2] = 8'h32; vld = 4'b0110;
    push();
    tick();
    rst_n = 1'b1;
    wait_send(20, "ar_first", n);
    chk("ar_first_gid", 32'(grant_id), 1);
    wait_idle(200, "ar_idle");

    // Randomized traffic checked by the models in tick()
    rnd_raise = 1; maxw = 0;
    for (int k = 0; k < 30; k++) wait_send(300, "rnd_to", n);
    chk("starve", 32'(maxw <= 120), 1);
    rnd_raise = 0;
    wait_idle(1000, "rnd_idle");

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
